// File: rtl/framer_pkg.sv
// ---------------------------------------------------------------------------
// framer_pkg
// Shared types and helpers for the packet framer.
//   state_e       : framer FSM state encoding
//   DEFAULT_SOF   : start-of-frame marker used when no override is given
//   build_header  : packs {SOF, PKT_LEN[7:0]} into the 16-bit header field
// ---------------------------------------------------------------------------
package framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        CHK,
        TAIL
    } state_e;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // The header occupies the low 16 bits; the caller zero-extends to DW.
    function automatic logic [15:0] build_header(input logic [7:0]  sof,
                                                 input int unsigned pkt_len);
        logic [7:0] len8;
        len8 = pkt_len[7:0];
        return {sof, len8};
    endfunction

endpackage

// File: rtl/hs_out_reg.sv
// ---------------------------------------------------------------------------
// hs_out_reg
// Output register stage for a req/ack link. Holds data/valid stable until the
// consumer takes the word; a new word may be loaded in the same cycle the
// current one is taken.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture data_i and raise req_o (only when ready_o is high)
//   data_i    : word to be loaded
//   ack_i     : downstream accepts d_o this cycle
//   ready_o   : register is empty or being emptied this cycle
//   d_o,req_o : registered output word and its valid flag
// ---------------------------------------------------------------------------
module hs_out_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ack_i,
    output logic          ready_o,
    output logic [DW-1:0] d_o,
    output logic          req_o
);

    logic [DW-1:0] d_q;
    logic          req_q;

    assign ready_o = ~req_q | ack_i;
    assign d_o     = d_q;
    assign req_o   = req_q;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every flop
            // samples pre-edge values regardless of statement order.
            d_q   <= '0;
            req_q <= 1'b0;
        end else if (load_i) begin
            d_q   <= data_i;
            req_q <= 1'b1;
        end else if (req_q && ack_i) begin
            req_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pkt_framer.sv
// ---------------------------------------------------------------------------
// pkt_framer
// Drains words from an upstream req/ack FIFO and emits frames of
// header, PKT_LEN payload words, checksum trailer on a req/ack output.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   d_in     : payload word from upstream
//   req_in   : upstream word valid
//   ack_in   : framer accepts d_in this cycle (combinational)
//   d_out    : framed output word (registered)
//   req_out  : d_out valid (registered)
//   ack_out  : downstream accepts d_out
//   pkt_cnt  : completed frames, wraps mod 2^16
//   busy     : FSM not idle
// ---------------------------------------------------------------------------
module pkt_framer
    import framer_pkg::*;
#(
    parameter int         DW      = 16,
    parameter int         PKT_LEN = 4,
    parameter logic [7:0] SOF     = DEFAULT_SOF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_in,
    input  logic          req_in,
    output logic          ack_in,
    output logic [DW-1:0] d_out,
    output logic          req_out,
    input  logic          ack_out,
    output logic [15:0]   pkt_cnt,
    output logic          busy
);

    if (DW < 16 || PKT_LEN < 1 || PKT_LEN > 255) begin : g_param_check
        $error("pkt_framer: DW must be >= 16 and PKT_LEN in 1..255");
    end

    localparam logic [DW-1:0] HEADER   = DW'(build_header(SOF, PKT_LEN));
    localparam logic [7:0]    LAST_IDX = 8'(PKT_LEN - 1);

    state_e        state_q;
    logic [DW-1:0] sum_q;
    logic [7:0]    cnt_q;
    logic [15:0]   pkt_cnt_q;

    logic          out_ready;
    logic          hs_load;
    logic [DW-1:0] hs_data;
    logic          in_fire;
    logic          out_fire;

    // ack_out feeds ack_in combinationally so a word can stream through the
    // output register every cycle while downstream keeps ack_out high.
    assign ack_in   = (state_q == PAY) & out_ready;
    assign in_fire  = req_in & ack_in;
    assign out_fire = req_out & ack_out;
    assign busy     = (state_q != IDLE);
    assign pkt_cnt  = pkt_cnt_q;

    // What, if anything, is loaded into the output register this cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no
        // latch is inferred.
        hs_load = 1'b0;
        hs_data = '0;
        unique case (state_q)
            IDLE: begin
                hs_load = req_in;
                hs_data = HEADER;
            end
            PAY: begin
                hs_load = in_fire;
                hs_data = d_in;
            end
            CHK: begin
                // sum_q already includes the last payload word here.
                hs_load = out_ready;
                hs_data = sum_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            cnt_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_in) begin
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (out_fire) state_q <= PAY;
                end
                PAY: begin
                    if (in_fire) begin
                        sum_q <= sum_q + d_in;
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST_IDX) state_q <= CHK;
                    end
                end
                CHK: begin
                    if (out_ready) state_q <= TAIL;
                end
                TAIL: begin
                    if (out_fire) begin
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    hs_out_reg #(
        .DW(DW)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (hs_load),
        .data_i (hs_data),
        .ack_i  (ack_out),
        .ready_o(out_ready),
        .d_o    (d_out),
        .req_o  (req_out)
    );

endmodule

// File: tb/tb_pkt_framer.sv
// ---------------------------------------------------------------------------
// tb_pkt_framer
// Self-checking bench for pkt_framer (DW=16, PKT_LEN=4, SOF=A5). The source
// behaves like a FIFO output: once req_in is raised it holds word and valid
// until accepted. Expected output words are queued as stimulus is driven and
// compared as the framer hands them downstream.
// ---------------------------------------------------------------------------
module tb_pkt_framer;

    localparam int          PKT_LEN  = 4;
    localparam logic [15:0] HDR_WORD = 16'hA504;

    typedef enum {K_HDR, K_PAY, K_TRL} kind_e;
    typedef struct {
        logic [15:0] data;
        kind_e       kind;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        req_in;
    logic        ack_in;
    logic [15:0] d_out;
    logic        req_out;
    logic        ack_out;
    logic [15:0] pkt_cnt;
    logic        busy;

    pkt_framer #(
        .DW     (16),
        .PKT_LEN(PKT_LEN),
        .SOF    (8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .d_in   (d_in),
        .req_in (req_in),
        .ack_in (ack_in),
        .d_out  (d_out),
        .req_out(req_out),
        .ack_out(ack_out),
        .pkt_cnt(pkt_cnt),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    exp_t        sb_q[$];
    logic [15:0] src_q[$];
    int          pos;
    logic [15:0] msum;
    bit          hdr_pushed;
    int          exp_pkt;
    bit          src_hold;
    bit          hold_pending;
    logic [15:0] hold_data;
    int          cyc = 0;
    int          fire_cyc[$];
    logic [15:0] fire_dat[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        pos          = 0;
        msum         = '0;
        hdr_pushed   = 1'b0;
        exp_pkt      = 0;
        src_hold     = 1'b0;
        hold_pending = 1'b0;
    endtask

    // Called just after a negedge: set up this cycle's inputs.
    task automatic drive(input bit want, input bit ack);
        exp_t e;
        ack_out = ack;
        if (!src_hold) begin
            if (want && src_q.size() > 0) begin
                req_in = 1'b1;
                d_in   = src_q[0];
            end else begin
                req_in = 1'b0;
                d_in   = 16'($urandom);
            end
        end
        if (req_in && pos == 0 && !hdr_pushed) begin
            e.data = HDR_WORD;
            e.kind = K_HDR;
            sb_q.push_back(e);
            hdr_pushed = 1'b1;
        end
    endtask

    // Evaluate this cycle's transfers, then advance to the next negedge.
    task automatic tick();
        bit   in_fire;
        bit   out_fire;
        exp_t e;
        #1;
        in_fire  = req_in && ack_in;
        out_fire = req_out && ack_out;
        if (!rst) begin
            if (hold_pending) begin
                check("hold_req", req_out, 1);
                check("hold_data", d_out, hold_data);
            end
            if (out_fire) begin
                fire_cyc.push_back(cyc);
                fire_dat.push_back(d_out);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    case (e.kind)
                        K_HDR:   check("hdr", d_out, e.data);
                        K_PAY:   check("pay", d_out, e.data);
                        default: begin
                            check("trl", d_out, e.data);
                            check("pkt_cnt", pkt_cnt, exp_pkt);
                            exp_pkt++;
                        end
                    endcase
                end
            end
            if (in_fire) begin
                void'(src_q.pop_front());
                e.data = d_in;
                e.kind = K_PAY;
                sb_q.push_back(e);
                msum = msum + d_in;
                pos++;
                if (pos == PKT_LEN) begin
                    e.data = msum;
                    e.kind = K_TRL;
                    sb_q.push_back(e);
                    pos        = 0;
                    msum       = '0;
                    hdr_pushed = 1'b0;
                end
            end
            src_hold     = req_in && !in_fire;
            hold_pending = req_out && !ack_out;
            hold_data    = d_out;
        end
        @(posedge clk);
        if (rst) model_reset();
        cyc++;
        @(negedge clk);
    endtask

    // mode 0: continuous source, ack_out=1; mode 1: alternating source;
    // mode 2: random source and sink.
    task automatic run(input int mode, input int budget);
        int i;
        i = 0;
        while (i < budget && !(src_q.size() == 0 && sb_q.size() == 0 && !src_hold)) begin
            case (mode)
                0:       drive(1'b1, 1'b1);
                1:       drive(cyc[0], 1'b1);
                default: drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
            endcase
            tick();
            i++;
        end
        check("drain", sb_q.size() + src_q.size(), 0);
        drive(1'b0, 1'b1);
        #1;
        check("idle_busy", busy, 0);
        check("idle_req", req_out, 0);
        check("idle_pkt_cnt", pkt_cnt, exp_pkt);
        tick();
    endtask

    task automatic start_test(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        fire_cyc.delete();
        fire_dat.delete();
        src_q = '{w0, w1, w2, w3};
    endtask

    task automatic check_trailer(input string tag, input logic [15:0] exp);
        check({tag, "_nwords"}, fire_dat.size(), PKT_LEN + 2);
        if (fire_dat.size() == PKT_LEN + 2) begin
            check({tag, "_header"}, fire_dat[0], HDR_WORD);
            check({tag, "_trailer"}, fire_dat[PKT_LEN + 1], exp);
        end
    endtask

    initial begin
        int need;
        rst     = 1'b1;
        req_in  = 1'b0;
        d_in    = '0;
        ack_out = 1'b0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        drive(1'b0, 1'b0);
        #1;
        check("rst_d_out", d_out, 0);
        check("rst_req_out", req_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_ack_in", ack_in, 0);
        tick();

        // Basic frame, streaming.
        start_test(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        run(0, 50);
        check_trailer("basic", 16'h000A);
        if (fire_cyc.size() == PKT_LEN + 2) begin
            check("basic_bubble", fire_cyc[1] - fire_cyc[0], 2);
            check("basic_stream", fire_cyc[4] - fire_cyc[1], 3);
        end
        check("basic_pkt_cnt", pkt_cnt, 1);

        // Header backpressure.
        start_test(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        drive(1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            #1;
            check("bp_req_out", req_out, 1);
            check("bp_d_out", d_out, HDR_WORD);
            check("bp_ack_in", ack_in, 0);
            tick();
        end
        run(0, 50);
        check_trailer("bp", 16'h0A0A);

        // Checksum wrap.
        start_test(16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000);
        run(0, 50);
        check_trailer("wrap", 16'h0000);

        // Upstream bubbles.
        start_test(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        run(1, 80);
        check_trailer("bubble", 16'h00A0);
        check("bubble_pkt_cnt", pkt_cnt, 4);

        // Reset mid-frame: source and sink keep handshaking during reset.
        start_test(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        for (int i = 0; i < 50 && pos < 2; i++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        check("mid_words", pos, 2);
        rst = 1'b1;
        drive(1'b1, 1'b1);
        tick();
        rst = 1'b0;
        src_q.delete();
        drive(1'b0, 1'b1);
        #1;
        check("mid_req_out", req_out, 0);
        check("mid_busy", busy, 0);
        check("mid_pkt_cnt", pkt_cnt, 0);
        tick();
        start_test(16'h0005, 16'h0006, 16'h0007, 16'h0008);
        run(0, 50);
        check_trailer("after_rst", 16'h001A);

        // Random soak.
        for (int i = 0; i < 1000; i++) begin
            while (src_q.size() < 2) src_q.push_back(16'($urandom));
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
            tick();
        end
        // Keep only what completes the frame in flight.
        need = (PKT_LEN - pos) % PKT_LEN;
        if (pos == 0 && hdr_pushed) need = PKT_LEN;
        while (src_q.size() > need) void'(src_q.pop_back());
        run(2, 400);
        check("soak_frames", exp_pkt >= 10, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
